piso_stream: RTL and testbench

- Parametrised parallel-in/serial-out shifter with valid/ready handshakes on both sides.
- Accepts a WIDTH-bit word from an upstream producer and emits it one bit per accepted beat, LSB-first or MSB-first.
- Flags the last bit of each word and supports back-to-back words with no idle bubble.
- Sits between a word-oriented datapath and a bit-serial link, such as a UART/SPI transmit front end.

---
 rtl/piso_pkg.sv | 25 ++
 rtl/piso_bit_cnt.sv | 38 +++
 rtl/piso_stream.sv | 112 +++++++++++
 tb/tb_piso_stream.sv | 186 ++++++++++++++++++
 4 files changed

// File: rtl/piso_pkg.sv
// ============================================================================
// Module      : piso_pkg
// Description : Shared state encoding and sizing helper for the piso_stream
//               parallel-in/serial-out shifter.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package piso_pkg;

    // ST_PARITY is only reachable when PISO_PARITY_EN is defined.
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SHIFT  = 2'd1,
        ST_PARITY = 2'd2
    } piso_state_e;

    // Sized to hold WIDTH, the parity beat index, without wrapping.
    function automatic int piso_cnt_w(input int width);
        return $clog2(width + 1);
    endfunction

endpackage : piso_pkg

`default_nettype wire

// File: rtl/piso_bit_cnt.sv
// ============================================================================
// Module      : piso_bit_cnt
// Description : Up-counter with synchronous clear, count enable and a
//               terminal-count flag; clear has priority over enable.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module piso_bit_cnt #(
    parameter int               CNT_W  = 4,
    parameter logic [CNT_W-1:0] TC_VAL = '1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_clr,
    input  logic             i_en,
    output logic [CNT_W-1:0] o_cnt,
    output logic             o_tc
);

    logic [CNT_W-1:0] r_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (i_clr) begin
            r_cnt <= '0;
        end else if (i_en) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign o_cnt = r_cnt;
    assign o_tc  = (r_cnt == TC_VAL);

endmodule : piso_bit_cnt

`default_nettype wire

// File: rtl/piso_stream.sv
// ============================================================================
// Module      : piso_stream
// Description : Parallel-in/serial-out shifter with valid/ready on both
//               sides, LSB- or MSB-first, zero-bubble back-to-back words.
//               Optional macro PISO_PARITY_EN appends an even-parity beat.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module piso_stream
    import piso_pkg::*;
#(
    parameter int WIDTH     = 8,
    parameter bit MSB_FIRST = 1'b0
) (
    input  logic             clk,
    input  logic             clr_n,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_valid,
    output logic             in_ready,
    output logic             ser_out,
    output logic             ser_valid,
    input  logic             ser_ready,
    output logic             ser_last,
    output logic             busy
);

    localparam int               CNT_W    = piso_cnt_w(WIDTH);
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(WIDTH - 1);

    piso_state_e      r_state;
    logic [WIDTH-1:0] r_shift;
    logic [CNT_W-1:0] w_cnt;
    logic             w_cnt_tc;
    logic             w_head;
    logic [WIDTH-1:0] w_shift_nxt;
    logic             w_word_acc;
    logic             w_bit_acc;
    logic             w_last_acc;

`ifdef PISO_PARITY_EN
    logic             r_parity;
`endif

    assign w_head      = MSB_FIRST ? r_shift[WIDTH-1] : r_shift[0];
    assign w_shift_nxt = MSB_FIRST ? {r_shift[WIDTH-2:0], 1'b0}
                                   : {1'b0, r_shift[WIDTH-1:1]};

    assign ser_valid = (r_state != ST_IDLE);
    assign busy      = (r_state != ST_IDLE);

`ifdef PISO_PARITY_EN
    assign ser_last = (r_state == ST_PARITY);
    assign ser_out  = (r_state == ST_PARITY) ? r_parity : w_head;
`else
    assign ser_last = (r_state == ST_SHIFT) && w_cnt_tc;
    assign ser_out  = w_head;
`endif

    // The only combinational input-to-output path: ser_ready -> in_ready.
    assign in_ready   = (r_state == ST_IDLE) || (ser_last && ser_ready);
    assign w_word_acc = in_valid && in_ready;
    assign w_bit_acc  = ser_valid && ser_ready;
    assign w_last_acc = w_bit_acc && ser_last;

    piso_bit_cnt #(
        .CNT_W  (CNT_W),
        .TC_VAL (LAST_IDX)
    ) u_bit_cnt (
        .clk   (clk),
        .rst_n (clr_n),
        .i_clr (w_word_acc || w_last_acc),
        .i_en  (w_bit_acc),
        .o_cnt (w_cnt),
        .o_tc  (w_cnt_tc)
    );

    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            r_state  <= ST_IDLE;
            r_shift  <= '0;
`ifdef PISO_PARITY_EN
            r_parity <= 1'b0;
`endif
        end else if (w_word_acc) begin
            // Covers both the IDLE load and the zero-bubble reload.
            r_state  <= ST_SHIFT;
            r_shift  <= in_data;
`ifdef PISO_PARITY_EN
            r_parity <= ^in_data;
`endif
        end else if (w_bit_acc) begin
            r_shift <= w_shift_nxt;
            case (r_state)
                ST_SHIFT: begin
                    if (w_cnt_tc) begin
`ifdef PISO_PARITY_EN
                        r_state <= ST_PARITY;
`else
                        r_state <= ST_IDLE;
`endif
                    end
                end
                ST_PARITY: r_state <= ST_IDLE;
                default:   r_state <= r_state;
            endcase
        end
    end

endmodule : piso_stream

`default_nettype wire

// File: tb/tb_piso_stream.sv
// ============================================================================
// Module      : tb_piso_stream
// Description : Self-checking bench for piso_stream (LSB- and MSB-first
//               instances side by side) against a word/beat-index model.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_piso_stream;

    localparam int W = 8;
`ifdef PISO_PARITY_EN
    localparam int BEATS = W + 1;
`else
    localparam int BEATS = W;
`endif

    logic         clk = 1'b0;
    logic         clr_n = 1'b0;
    logic [W-1:0] in_data = '0;
    logic         in_valid = 1'b0;
    logic         ser_ready = 1'b0;

    logic l_in_ready, l_ser_out, l_ser_valid, l_ser_last, l_busy;
    logic m_in_ready, m_ser_out, m_ser_valid, m_ser_last, m_busy;

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model: the word being sent, the beat index, and whether held.
    bit           md_hold = 1'b0;
    int           md_pos  = 0;
    logic [W-1:0] md_word = '0;

    always #5 clk = ~clk;

    piso_stream #(.WIDTH(W), .MSB_FIRST(1'b0)) u_dut_lsb (
        .clk       (clk),
        .clr_n     (clr_n),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (l_in_ready),
        .ser_out   (l_ser_out),
        .ser_valid (l_ser_valid),
        .ser_ready (ser_ready),
        .ser_last  (l_ser_last),
        .busy      (l_busy)
    );

    piso_stream #(.WIDTH(W), .MSB_FIRST(1'b1)) u_dut_msb (
        .clk       (clk),
        .clr_n     (clr_n),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (m_in_ready),
        .ser_out   (m_ser_out),
        .ser_valid (m_ser_valid),
        .ser_ready (ser_ready),
        .ser_last  (m_ser_last),
        .busy      (m_busy)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    endtask

    function automatic bit exp_bit(input logic [W-1:0] word, input int pos, input bit msb);
        if (pos >= W) return ^word;
        return msb ? word[W-1-pos] : word[pos];
    endfunction

    task automatic check_reset_outputs();
        check("rst_lsb_in_ready",  l_in_ready,  1'b1);
        check("rst_lsb_ser_out",   l_ser_out,   1'b0);
        check("rst_lsb_ser_valid", l_ser_valid, 1'b0);
        check("rst_lsb_ser_last",  l_ser_last,  1'b0);
        check("rst_lsb_busy",      l_busy,      1'b0);
        check("rst_msb_in_ready",  m_in_ready,  1'b1);
        check("rst_msb_ser_out",   m_ser_out,   1'b0);
        check("rst_msb_ser_valid", m_ser_valid, 1'b0);
        check("rst_msb_busy",      m_busy,      1'b0);
    endtask

    // Asynchronous reset asserted between edges, outputs checked before any edge.
    task automatic do_reset();
        @(negedge clk);
        in_valid  = 1'b1;
        in_data   = 8'hC3;
        ser_ready = 1'b1;
        #2;
        clr_n = 1'b0;
        #1;
        check_reset_outputs();
        md_hold = 1'b0;
        md_pos  = 0;
        @(posedge clk);
        #1;
        check_reset_outputs();
        @(negedge clk);
        in_valid = 1'b0;
        clr_n    = 1'b1;
    endtask

    task automatic step(input logic v, input logic [W-1:0] d, input logic r);
        bit e_last, e_rdy, e_lsb, e_msb;
        @(negedge clk);
        in_valid  = v;
        in_data   = d;
        ser_ready = r;
        #1;
        e_last = md_hold && (md_pos == BEATS - 1);
        e_rdy  = !md_hold || (e_last && r);
        e_lsb  = md_hold ? exp_bit(md_word, md_pos, 1'b0) : 1'b0;
        e_msb  = md_hold ? exp_bit(md_word, md_pos, 1'b1) : 1'b0;
        check("lsb_ser_valid", l_ser_valid, md_hold);
        check("lsb_ser_last",  l_ser_last,  e_last);
        check("lsb_in_ready",  l_in_ready,  e_rdy);
        check("lsb_busy",      l_busy,      md_hold);
        check("lsb_ser_out",   l_ser_out,   e_lsb);
        check("msb_ser_valid", m_ser_valid, md_hold);
        check("msb_ser_last",  m_ser_last,  e_last);
        check("msb_in_ready",  m_in_ready,  e_rdy);
        check("msb_ser_out",   m_ser_out,   e_msb);
        @(posedge clk);
        if (md_hold && r) begin
            md_pos++;
            if (md_pos == BEATS) md_hold = 1'b0;
        end
        if (v && e_rdy) begin
            md_word = d;
            md_pos  = 0;
            md_hold = 1'b1;
        end
    endtask

    initial begin
        #1;
        check_reset_outputs();
        @(negedge clk);
        clr_n = 1'b1;

        // Single word A5 at full rate, then idle.
        step(1'b1, 8'hA5, 1'b1);
        for (int i = 0; i < BEATS + 2; i++) step(1'b0, 8'h00, 1'b1);

        // Back-to-back FF then 00 with in_valid held high.
        step(1'b1, 8'hFF, 1'b1);
        for (int i = 0; i < BEATS; i++) step(1'b1, 8'h00, 1'b1);
        for (int i = 0; i < BEATS + 2; i++) step(1'b0, 8'h00, 1'b1);

        // Stall: 81, ser_ready low for 3 cycles after beat 2.
        step(1'b1, 8'h81, 1'b1);
        step(1'b0, 8'h00, 1'b1);
        step(1'b0, 8'h00, 1'b1);
        for (int i = 0; i < 3; i++) step(1'b0, 8'h00, 1'b0);
        for (int i = 0; i < BEATS + 2; i++) step(1'b0, 8'h00, 1'b1);

        // Reset after beat 3 of 3C, then a clean 01.
        step(1'b1, 8'h3C, 1'b1);
        for (int i = 0; i < 3; i++) step(1'b0, 8'h00, 1'b1);
        do_reset();
        step(1'b1, 8'h01, 1'b1);
        for (int i = 0; i < BEATS + 2; i++) step(1'b0, 8'h00, 1'b1);

        // Parity examples (plain data beats when parity is not built in).
        step(1'b1, 8'h07, 1'b1);
        step(1'b1, 8'h03, 1'b0);
        for (int i = 0; i < 2 * BEATS; i++) step(1'b0, 8'h00, 1'b1);

        // Randomised traffic with occasional mid-stream reset.
        for (int i = 0; i < 2000; i++) begin
            if ($urandom_range(0, 399) == 0) do_reset();
            step(($urandom_range(0, 9) < 7) ? 1'b1 : 1'b0,
                 W'($urandom),
                 ($urandom_range(0, 9) < 7) ? 1'b1 : 1'b0);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule : tb_piso_stream

`default_nettype wire
